// File: rtl/jls_pkg.sv
// Shared JPEG-LS types: pixel, lane status and group geometry.
package jls_pkg;

    localparam int unsigned GRP_PX = 8;

    typedef logic [7:0] pix_t;

    typedef enum logic [1:0] {
        ST_PAD = 2'd0,
        ST_PIX = 2'd1,
        ST_EOL = 2'd2,
        ST_EOI = 2'd3
    } lane_st_t;

endpackage

// File: rtl/jls_lbuf_ram.sv
// Line buffer for the previous image row: simple dual-port RAM, registered read with enable.
module jls_lbuf_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Same-address read and write return the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/jls_row_sched.sv
// JPEG-LS context-stage row scheduler: line buffer, above-row pipeline, group outputs.
// Optional config check is built when SCHED_CFG_CHECK_EN is defined.
module jls_row_sched
    import jls_pkg::*;
#(
    parameter int unsigned MAX_GRP = 64,
    parameter int unsigned HW      = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          ena,
    input  logic                          cfg_start,
    input  logic [$clog2(8*MAX_GRP):0]    cfg_w,
    input  logic [HW-1:0]                 cfg_h,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  pix_t [1:8]                    in_x,
    output logic                          o_sl,
    output logic                          o_sp,
    output logic                          o_vl,
    output logic [1:8][1:0]               o_st,
    output pix_t [1:9]                    o_b,
    output pix_t [1:8]                    o_x,
    output logic                          o_busy,
    output logic                          o_cfg_err
);

    localparam int unsigned WW = $clog2(8*MAX_GRP) + 1;
    localparam int unsigned GW = $clog2(MAX_GRP + 1);
    localparam int unsigned AW = $clog2(MAX_GRP);

    typedef enum logic [1:0] {StIdle, StPref, StRun} state_t;

    state_t         state_q, state_d;
    logic           pref_q;
    logic [GW-1:0]  grp_q, ng_q;
    logic [HW-1:0]  row_q, h_q;
    logic [3:0]     last_lane_q;
    pix_t [1:8]     ab0_q;
    pix_t [1:8]     rd_data;

    logic           start_ok, acc, last_grp, last_row;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    pix_t [1:8]     x_m;
    logic [1:8][1:0] st_n;
    pix_t [1:9]     b_n;
    logic [2:0]     cfg_ll;

`ifdef SCHED_CFG_CHECK_EN
    logic cfg_bad, err_q;
    assign cfg_bad  = (cfg_w == '0) || (cfg_w > WW'(8*MAX_GRP)) || (cfg_h == '0);
    // Once set, the error blocks every later start until reset.
    assign start_ok = cfg_start && (state_q == StIdle) && !cfg_bad && !err_q;
    assign o_cfg_err = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (ena && cfg_start && (state_q == StIdle) && cfg_bad) begin
            err_q <= 1'b1;
        end
    end
`else
    assign start_ok  = cfg_start && (state_q == StIdle);
    assign o_cfg_err = 1'b0;
`endif

    assign in_rdy   = (state_q == StRun) && ena;
    assign acc      = in_rdy && in_vld;
    assign last_grp = (grp_q == ng_q - GW'(1));
    assign last_row = (row_q == h_q - HW'(1));
    assign o_busy   = (state_q != StIdle);
    assign cfg_ll   = 3'(cfg_w - WW'(1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_ok) state_d = StPref;
            StPref: if (pref_q) state_d = StRun;
            StRun:  if (acc && last_grp) state_d = last_row ? StIdle : StPref;
            default: state_d = StIdle;
        endcase
    end

    // Reads run two groups ahead of the group being written.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        if (state_q == StPref) begin
            rd_en   = 1'b1;
            rd_addr = (pref_q && ng_q > GW'(1)) ? AW'(1) : '0;
        end else if (acc && ((grp_q + GW'(2)) < ng_q)) begin
            rd_en   = 1'b1;
            rd_addr = AW'(grp_q + GW'(2));
        end
    end

    always_comb begin
        x_m  = '0;
        st_n = '0;
        for (int l = 1; l <= 8; l++) begin
            if (!last_grp || (4'(l) <= last_lane_q)) begin
                x_m[l]  = in_x[l];
                st_n[l] = (last_grp && 4'(l) == last_lane_q) ? (last_row ? ST_EOI : ST_EOL)
                                                             : ST_PIX;
            end
        end
        b_n = '0;
        if (row_q != '0) begin
            b_n[1:8] = ab0_q;
            b_n[9]   = last_grp ? ab0_q[last_lane_q] : rd_data[1];
        end
    end

    jls_lbuf_ram #(
        .DEPTH (MAX_GRP),
        .WIDTH (64),
        .AW    (AW)
    ) u_lbuf (
        .clk   (clk),
        .we    (acc),
        .waddr (AW'(grp_q)),
        .wdata (x_m),
        .re    (rd_en && ena),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pref_q      <= 1'b0;
            grp_q       <= '0;
            row_q       <= '0;
            ng_q        <= '0;
            h_q         <= '0;
            last_lane_q <= '0;
            ab0_q       <= '0;
            o_sl        <= 1'b0;
            o_sp        <= 1'b0;
            o_vl        <= 1'b0;
            o_st        <= '0;
            o_b         <= '0;
            o_x         <= '0;
        end else if (ena) begin
            o_vl <= acc;
            if (start_ok) begin
                ng_q        <= GW'((cfg_w + WW'(7)) >> 3);
                h_q         <= cfg_h;
                last_lane_q <= {1'b0, cfg_ll} + 4'd1;
                grp_q       <= '0;
                row_q       <= '0;
                pref_q      <= 1'b0;
            end
            if (state_q == StPref) begin
                pref_q <= !pref_q;
                if (pref_q) ab0_q <= rd_data;
            end
            if (acc) begin
                ab0_q <= rd_data;
                o_sl  <= (row_q == '0);
                o_sp  <= (grp_q == '0);
                o_st  <= st_n;
                o_b   <= b_n;
                o_x   <= x_m;
                if (last_grp) begin
                    grp_q <= '0;
                    row_q <= row_q + HW'(1);
                end else begin
                    grp_q <= grp_q + GW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_jls_row_sched.sv
// Scoreboard bench for jls_row_sched: driver pushes expected groups, monitor pops on o_vl.
module tb_jls_row_sched;
    import jls_pkg::*;

    logic            clk = 1'b0;
    logic            rstn, ena, cfg_start, in_vld, in_rdy;
    logic [9:0]      cfg_w;
    logic [15:0]     cfg_h;
    pix_t [1:8]      in_x;
    logic            o_sl, o_sp, o_vl, o_busy, o_cfg_err;
    logic [1:8][1:0] o_st;
    pix_t [1:9]      o_b;
    pix_t [1:8]      o_x;

    jls_row_sched #(
        .MAX_GRP (64),
        .HW      (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ena       (ena),
        .cfg_start (cfg_start),
        .cfg_w     (cfg_w),
        .cfg_h     (cfg_h),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_x      (in_x),
        .o_sl      (o_sl),
        .o_sp      (o_sp),
        .o_vl      (o_vl),
        .o_st      (o_st),
        .o_b       (o_b),
        .o_x       (o_x),
        .o_busy    (o_busy),
        .o_cfg_err (o_cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sl;
        logic        sp;
        logic [15:0] st;
        logic [71:0] b;
        logic [63:0] x;
    } grp_exp_t;

    grp_exp_t   sb_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] prev_row [512];
    logic       mon_en;
    grp_exp_t   mon_exp, mon_act;

    function automatic logic [7:0] px(input int fid, input int r, input int c);
        return 8'(fid * 64 + r * 17 + c + 1);
    endfunction

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Monitor: one pop per group presented on an enabled edge.
    initial begin
        forever begin
            @(posedge clk);
            mon_en = ena && rstn;
            #1;
            if (mon_en && o_vl) begin
                n_cmp++;
                mon_act = {o_sl, o_sp, o_st, o_b, o_x};
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL group_unexpected: got %0h required no group", mon_act);
                end else begin
                    mon_exp = sb_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        n_bad++;
                        $display("FAIL group: got %0h required %0h", mon_act, mon_exp);
                    end
                end
            end
        end
    end

    task automatic run_frame(input int w, input int h, input int fid,
                             input int stall_at, input int abort_after);
        int ng, cnt, t, c;
        logic [63:0] xw;
        logic [7:0]  pv;
        logic [154:0] snap;
        grp_exp_t e;
        ng  = (w + 7) / 8;
        cnt = 0;
        @(negedge clk);
        cfg_w     = 10'(w);
        cfg_h     = 16'(h);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        #1 check("busy_after_start", 160'(o_busy), 160'(1));
        for (int r = 0; r < h; r++) begin
            for (int g = 0; g < ng; g++) begin
                e = '0;
                for (int l = 0; l < 8; l++) begin
                    c  = g * 8 + l;
                    pv = (c < w) ? px(fid, r, c) : 8'h00;
                    xw[63-8*l -: 8]  = pv;
                    e.x[63-8*l -: 8] = pv;
                    if (c < w) begin
                        e.st[15-2*l -: 2] = (c != w - 1) ? 2'd1 : (r == h - 1) ? 2'd3 : 2'd2;
                        e.b[71-8*l -: 8]  = (r == 0) ? 8'h00 : prev_row[c];
                    end
                end
                if (r != 0) e.b[7:0] = (g == ng - 1) ? prev_row[w-1] : prev_row[g*8+8];
                e.sl = (r == 0);
                e.sp = (g == 0);
                @(negedge clk);
                in_vld = 1'b1;
                in_x   = xw;
                #1;
                t = 0;
                while (!(in_rdy && ena) && t < 50) begin
                    @(negedge clk);
                    #1;
                    t++;
                end
                if (t >= 50) begin
                    check("accept_timeout", 160'(0), 160'(1));
                    in_vld = 1'b0;
                    return;
                end
                sb_q.push_back(e);
                cnt++;
                if (cnt == abort_after) begin
                    @(negedge clk);
                    in_vld = 1'b0;
                    return;
                end
                if (cnt == stall_at) begin
                    @(negedge clk);
                    ena    = 1'b0;
                    in_x   = '{default: 8'hAA};
                    #1 snap = {o_sl, o_sp, o_vl, o_st, o_b, o_x};
                    repeat (5) begin
                        @(negedge clk);
                        #1 check("stall_hold", 160'({o_sl, o_sp, o_vl, o_st, o_b, o_x}),
                                 160'(snap));
                    end
                    in_vld = 1'b0;
                    ena    = 1'b1;
                end
            end
            for (int k = 0; k < w; k++) prev_row[k] = px(fid, r, k);
        end
        @(negedge clk);
        in_vld = 1'b0;
        t = 0;
        while (o_busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        #1;
        check("busy_end", 160'(o_busy), 160'(0));
        check("sb_drained", 160'(sb_q.size()), 160'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn      = 1'b0;
        ena       = 1'b1;
        cfg_start = 1'b0;
        cfg_w     = '0;
        cfg_h     = '0;
        in_vld    = 1'b0;
        in_x      = '0;
        #13;
        check("reset_state", 160'({o_sl, o_sp, o_vl, o_busy, o_cfg_err, in_rdy, o_st, o_b, o_x}),
              160'(0));
        @(negedge clk);
        rstn = 1'b1;

        run_frame(16, 2, 1, -1, -1);
        // 13 px: group 1 carries px 8..12, so lane 5 ends the image.
        run_frame(13, 1, 2, -1, -1);
        run_frame(8, 3, 3, -1, -1);
        run_frame(24, 2, 4, 4, -1);

        run_frame(16, 4, 5, -1, 3);
        @(negedge clk);
        rstn = 1'b0;
        #1 check("reset_abort", 160'({o_sl, o_sp, o_vl, o_busy, in_rdy, o_st, o_b, o_x}),
                 160'(0));
        sb_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        run_frame(16, 2, 6, -1, -1);

`ifdef SCHED_CFG_CHECK_EN
        @(negedge clk);
        cfg_w = '0; cfg_h = 16'd1; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        #1 check("cfg_err_w0", 160'({o_cfg_err, o_busy}), 160'(2'b10));
        @(negedge clk);
        cfg_w = 10'd8; cfg_h = 16'd1; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        #1 check("cfg_err_sticky", 160'({o_cfg_err, o_busy}), 160'(2'b10));
`else
        check("cfg_err_tied", 160'(o_cfg_err), 160'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
